// File: rtl/privilege_trap_unit.sv
// Machine/supervisor trap and return controller with its CSR file.
// Takes interrupts, exceptions, mret and sret, then requests a one-cycle fetch redirect.
module privilege_trap_unit #(
    parameter int unsigned DATA_SIZE = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic                 illegal_instruction,
    input  logic                 ecall,
    input  logic                 mret,
    input  logic                 sret,
    input  logic [DATA_SIZE-1:0] pc,
    input  logic [31:0]          instruction,
    input  logic                 ext_irq,
    input  logic [11:0]          csr_addr,
    input  logic                 csr_wr_en,
    input  logic [DATA_SIZE-1:0] csr_wdata,
    output logic [DATA_SIZE-1:0] csr_rdata,
    output logic                 csr_addr_invalid,
    output logic [1:0]           privilege_mode,
    output logic                 redirect,
    output logic [DATA_SIZE-1:0] redirect_pc
);
    localparam int unsigned IdxW = $clog2(DATA_SIZE);
    localparam logic [DATA_SIZE-1:0] IrqCause = {1'b1, {(DATA_SIZE-5){1'b0}}, 4'd11};

    typedef enum logic {StIdle, StRedirect} state_e;

    state_e               state_q;
    logic [1:0]           priv_q;
    logic                 sie_q, mie_q, spie_q, mpie_q, spp_q;
    logic [1:0]           mpp_q;
    logic [DATA_SIZE-1:0] medeleg_q, mtvec_q, mepc_q, mcause_q, mtval_q;
    logic [DATA_SIZE-1:0] stvec_q, sepc_q, scause_q, stval_q, redirect_pc_q;

    logic                 valid_evt, irq_req;
    logic                 irq_take, ill_take, ecall_take, mret_take, sret_take;
    logic                 trap_take, event_take, to_s;
    logic [3:0]           exc_code;
    logic [DATA_SIZE-1:0] trap_cause, trap_tval, mstatus_val, sstatus_val, wdata_aligned;

    // Event decode in priority order; only one of the *_take flags can be set.
    always_comb begin
        valid_evt  = (state_q == StIdle) & instr_valid;
        irq_req    = ext_irq & ((priv_q != 2'b11) | mie_q);
        irq_take   = valid_evt & irq_req;
        ill_take   = valid_evt & ~irq_req & illegal_instruction;
        ecall_take = valid_evt & ~irq_req & ~illegal_instruction & ecall;
        mret_take  = valid_evt & ~irq_req & ~illegal_instruction & ~ecall & mret;
        sret_take  = valid_evt & ~irq_req & ~illegal_instruction & ~ecall & ~mret & sret;
        trap_take  = irq_take | ill_take | ecall_take;
        event_take = trap_take | mret_take | sret_take;

        exc_code   = ill_take ? 4'd2 : (4'd8 + {2'b00, priv_q});
        to_s       = ~irq_take & medeleg_q[IdxW'(exc_code)] & ~priv_q[1];
        trap_cause = irq_take ? IrqCause : DATA_SIZE'(exc_code);
        trap_tval  = ill_take ? DATA_SIZE'(instruction) : '0;

        wdata_aligned = {csr_wdata[DATA_SIZE-1:2], 2'b00};
    end

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[1]     = sie_q;
        mstatus_val[3]     = mie_q;
        mstatus_val[5]     = spie_q;
        mstatus_val[7]     = mpie_q;
        mstatus_val[8]     = spp_q;
        mstatus_val[12:11] = mpp_q;
        sstatus_val        = '0;
        sstatus_val[1]     = sie_q;
        sstatus_val[5]     = spie_q;
        sstatus_val[8]     = spp_q;

        csr_rdata        = '0;
        csr_addr_invalid = 1'b0;
        case (csr_addr)
            12'h300: csr_rdata = mstatus_val;
            12'h302: csr_rdata = medeleg_q;
            12'h305: csr_rdata = mtvec_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h100: csr_rdata = sstatus_val;
            12'h105: csr_rdata = stvec_q;
            12'h141: csr_rdata = sepc_q;
            12'h142: csr_rdata = scause_q;
            12'h143: csr_rdata = stval_q;
            default: csr_addr_invalid = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            priv_q        <= 2'b11;
            sie_q         <= 1'b0;
            mie_q         <= 1'b0;
            spie_q        <= 1'b0;
            mpie_q        <= 1'b0;
            spp_q         <= 1'b0;
            mpp_q         <= 2'b00;
            medeleg_q     <= '0;
            mtvec_q       <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            stvec_q       <= '0;
            sepc_q        <= '0;
            scause_q      <= '0;
            stval_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (event_take) begin
                        state_q <= StRedirect;
                    end
                    if (trap_take && to_s) begin
                        sepc_q        <= pc;
                        scause_q      <= trap_cause;
                        stval_q       <= trap_tval;
                        spie_q        <= sie_q;
                        sie_q         <= 1'b0;
                        spp_q         <= priv_q[0];
                        priv_q        <= 2'b01;
                        redirect_pc_q <= stvec_q;
                    end else if (trap_take) begin
                        mepc_q        <= pc;
                        mcause_q      <= trap_cause;
                        mtval_q       <= trap_tval;
                        mpie_q        <= mie_q;
                        mie_q         <= 1'b0;
                        mpp_q         <= priv_q;
                        priv_q        <= 2'b11;
                        redirect_pc_q <= mtvec_q;
                    end else if (mret_take) begin
                        priv_q        <= mpp_q;
                        mie_q         <= mpie_q;
                        mpie_q        <= 1'b1;
                        mpp_q         <= 2'b00;
                        redirect_pc_q <= mepc_q;
                    end else if (sret_take) begin
                        priv_q        <= spp_q ? 2'b01 : 2'b00;
                        sie_q         <= spie_q;
                        spie_q        <= 1'b1;
                        spp_q         <= 1'b0;
                        redirect_pc_q <= sepc_q;
                    end else if (csr_wr_en) begin
                        case (csr_addr)
                            12'h300: begin
                                sie_q  <= csr_wdata[1];
                                mie_q  <= csr_wdata[3];
                                spie_q <= csr_wdata[5];
                                mpie_q <= csr_wdata[7];
                                spp_q  <= csr_wdata[8];
                                mpp_q  <= csr_wdata[12:11];
                            end
                            12'h100: begin
                                sie_q  <= csr_wdata[1];
                                spie_q <= csr_wdata[5];
                                spp_q  <= csr_wdata[8];
                            end
                            12'h302: medeleg_q <= csr_wdata;
                            12'h305: mtvec_q   <= wdata_aligned;
                            12'h341: mepc_q    <= wdata_aligned;
                            12'h342: mcause_q  <= csr_wdata;
                            12'h343: mtval_q   <= csr_wdata;
                            12'h105: stvec_q   <= wdata_aligned;
                            12'h141: sepc_q    <= wdata_aligned;
                            12'h142: scause_q  <= csr_wdata;
                            12'h143: stval_q   <= csr_wdata;
                            default: ;
                        endcase
                    end
                end
                StRedirect: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    assign privilege_mode = priv_q;
    assign redirect       = (state_q == StRedirect);
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_privilege_trap_unit.sv
// Bench for privilege_trap_unit: CSR vector table, directed trap/return sequences,
// and randomized traffic checked against a field-level architectural model.
module tb_privilege_trap_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid, illegal_instruction, ecall, mret, sret, ext_irq;
    logic [63:0] pc;
    logic [31:0] instruction;
    logic [11:0] csr_addr;
    logic        csr_wr_en;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_addr_invalid;
    logic [1:0]  privilege_mode;
    logic        redirect;
    logic [63:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    privilege_trap_unit #(.DATA_SIZE(64)) dut (
        .clock              (clock),
        .reset              (reset),
        .instr_valid        (instr_valid),
        .illegal_instruction(illegal_instruction),
        .ecall              (ecall),
        .mret               (mret),
        .sret               (sret),
        .pc                 (pc),
        .instruction        (instruction),
        .ext_irq            (ext_irq),
        .csr_addr           (csr_addr),
        .csr_wr_en          (csr_wr_en),
        .csr_wdata          (csr_wdata),
        .csr_rdata          (csr_rdata),
        .csr_addr_invalid   (csr_addr_invalid),
        .privilege_mode     (privilege_mode),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc)
    );

    always #5 clock = ~clock;

    // Architectural model: mstatus kept as a whole word, other CSRs as plain values.
    logic [1:0]  m_priv = 2'b11;
    logic [63:0] m_mstatus = '0, m_medeleg = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;
    logic [63:0] m_mtval = '0, m_stvec = '0, m_sepc = '0, m_scause = '0, m_stval = '0;
    logic        m_redir = 1'b0;
    logic [63:0] m_rpc = '0;

    localparam logic [63:0] MstatusMask = 64'h19AA;
    localparam logic [63:0] SstatusMask = 64'h0122;
    localparam logic [63:0] IrqCause    = 64'h8000_0000_0000_000B;

    function automatic logic [63:0] model_read(input logic [11:0] a, output logic inv);
        inv = 1'b0;
        case (a)
            12'h300: return m_mstatus;
            12'h302: return m_medeleg;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h100: return m_mstatus & SstatusMask;
            12'h105: return m_stvec;
            12'h141: return m_sepc;
            12'h142: return m_scause;
            12'h143: return m_stval;
            default: begin
                inv = 1'b1;
                return 64'h0;
            end
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [63:0] d);
        case (a)
            12'h300: m_mstatus = d & MstatusMask;
            12'h100: m_mstatus = (m_mstatus & ~SstatusMask) | (d & SstatusMask);
            12'h302: m_medeleg = d;
            12'h305: m_mtvec = d & ~64'h3;
            12'h341: m_mepc = d & ~64'h3;
            12'h342: m_mcause = d;
            12'h343: m_mtval = d;
            12'h105: m_stvec = d & ~64'h3;
            12'h141: m_sepc = d & ~64'h3;
            12'h142: m_scause = d;
            12'h143: m_stval = d;
            default: ;
        endcase
    endtask

    task automatic model_trap(input logic [63:0] cause, input logic [63:0] tval, input bit irq);
        if (!irq && m_medeleg[cause[5:0]] && m_priv <= 2'b01) begin
            m_sepc = pc;
            m_scause = cause;
            m_stval = tval;
            m_mstatus[5] = m_mstatus[1];
            m_mstatus[1] = 1'b0;
            m_mstatus[8] = m_priv[0];
            m_priv = 2'b01;
            m_rpc = m_stvec;
        end else begin
            m_mepc = pc;
            m_mcause = cause;
            m_mtval = tval;
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
            m_mstatus[12:11] = m_priv;
            m_priv = 2'b11;
            m_rpc = m_mtvec;
        end
        m_redir = 1'b1;
    endtask

    task automatic model_edge();
        bit evt;
        if (!reset) begin
            m_priv = 2'b11;
            {m_mstatus, m_medeleg, m_mtvec, m_mepc, m_mcause} = '0;
            {m_mtval, m_stvec, m_sepc, m_scause, m_stval} = '0;
            m_redir = 1'b0;
            m_rpc = '0;
            return;
        end
        if (m_redir) begin
            m_redir = 1'b0;
            return;
        end
        evt = 1'b0;
        if (instr_valid) begin
            evt = 1'b1;
            if (ext_irq && (m_priv != 2'b11 || m_mstatus[3])) model_trap(IrqCause, 64'h0, 1'b1);
            else if (illegal_instruction) model_trap(64'd2, {32'h0, instruction}, 1'b0);
            else if (ecall) model_trap(64'd8 + 64'(m_priv), 64'h0, 1'b0);
            else if (mret) begin
                m_priv = m_mstatus[12:11];
                m_mstatus[3] = m_mstatus[7];
                m_mstatus[7] = 1'b1;
                m_mstatus[12:11] = 2'b00;
                m_rpc = m_mepc;
                m_redir = 1'b1;
            end else if (sret) begin
                m_priv = m_mstatus[8] ? 2'b01 : 2'b00;
                m_mstatus[1] = m_mstatus[5];
                m_mstatus[5] = 1'b1;
                m_mstatus[8] = 1'b0;
                m_rpc = m_sepc;
                m_redir = 1'b1;
            end else evt = 1'b0;
        end
        if (!evt && csr_wr_en) model_write(csr_addr, csr_wdata);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        illegal_instruction = 1'b0;
        ecall = 1'b0;
        mret = 1'b0;
        sret = 1'b0;
        ext_irq = 1'b0;
        csr_wr_en = 1'b0;
        csr_wdata = '0;
        pc = '0;
        instruction = '0;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic chk_csr(input string name, input logic [11:0] a, input logic [63:0] exp);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        idle_inputs();
        csr_addr = a;
        csr_wdata = d;
        csr_wr_en = 1'b1;
        step();
        csr_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic do_mret();
        idle_inputs();
        instr_valid = 1'b1;
        mret = 1'b1;
        step();
        idle_inputs();
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_inv;
    } csr_vec_t;

    csr_vec_t    vecs[15];
    logic [11:0] addr_list[12];

    initial begin
        logic [63:0] d;
        logic        inv;

        vecs[0]  = '{12'h7C0, 1'b1, 64'h55, 64'h0, 1'b1};
        vecs[1]  = '{12'h305, 1'b1, 64'h203, 64'h200, 1'b0};
        vecs[2]  = '{12'h105, 1'b1, 64'h107, 64'h104, 1'b0};
        vecs[3]  = '{12'h341, 1'b1, 64'hFFF, 64'hFFC, 1'b0};
        vecs[4]  = '{12'h141, 1'b1, 64'h41, 64'h40, 1'b0};
        vecs[5]  = '{12'h343, 1'b1, 64'h3, 64'h3, 1'b0};
        vecs[6]  = '{12'h143, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{12'h342, 1'b1, 64'h5, 64'h5, 1'b0};
        vecs[8]  = '{12'h142, 1'b1, 64'h7, 64'h7, 1'b0};
        vecs[9]  = '{12'h302, 1'b1, 64'h104, 64'h104, 1'b0};
        vecs[10] = '{12'h300, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h19AA, 1'b0};
        vecs[11] = '{12'h100, 1'b0, 64'h0, 64'h122, 1'b0};
        vecs[12] = '{12'h100, 1'b1, 64'h0, 64'h0, 1'b0};
        vecs[13] = '{12'h300, 1'b0, 64'h0, 64'h1888, 1'b0};
        vecs[14] = '{12'h000, 1'b0, 64'h0, 64'h0, 1'b1};
        addr_list = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342, 12'h343,
                      12'h100, 12'h105, 12'h141, 12'h142, 12'h143, 12'h7C0};

        idle_inputs();
        csr_addr = '0;
        reset = 1'b0;
        @(negedge clock);
        do_reset();
        chk("reset_priv", 64'(privilege_mode), 64'h3);
        chk("reset_redirect", 64'(redirect), 64'h0);
        chk("reset_redirect_pc", redirect_pc, 64'h0);
        for (int i = 0; i < 11; i++) chk_csr("reset_csr", addr_list[i], 64'h0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            csr_addr = vecs[i].addr;
            #1;
            chk("table_rdata", csr_rdata, vecs[i].exp_rdata);
            chk("table_invalid", 64'(csr_addr_invalid), 64'(vecs[i].exp_inv));
        end

        // U-mode ecall lands in M at mtvec
        do_reset();
        wr(12'h305, 64'h200);
        wr(12'h341, 64'h100);
        do_mret();
        chk("mret_to_u_priv", 64'(privilege_mode), 64'h0);
        step();
        instr_valid = 1'b1;
        ecall = 1'b1;
        pc = 64'h100;
        step();
        idle_inputs();
        chk("ecall_redirect", 64'(redirect), 64'h1);
        chk("ecall_redirect_pc", redirect_pc, 64'h200);
        chk("ecall_priv", 64'(privilege_mode), 64'h3);
        chk_csr("ecall_mcause", 12'h342, 64'h8);
        chk_csr("ecall_mepc", 12'h341, 64'h100);

        // Everything but reads is ignored while redirecting
        instr_valid = 1'b1;
        ecall = 1'b1;
        csr_wr_en = 1'b1;
        csr_addr = 12'h305;
        csr_wdata = 64'h999;
        step();
        idle_inputs();
        chk("flush_redirect", 64'(redirect), 64'h0);
        chk("flush_priv", 64'(privilege_mode), 64'h3);
        chk_csr("flush_mtvec", 12'h305, 64'h200);
        chk_csr("flush_mepc", 12'h341, 64'h100);

        // Interrupt outranks a simultaneous illegal instruction
        wr(12'h300, 64'h8);
        instr_valid = 1'b1;
        ext_irq = 1'b1;
        illegal_instruction = 1'b1;
        pc = 64'h700;
        instruction = 32'hDEAD;
        step();
        idle_inputs();
        chk("irq_redirect", 64'(redirect), 64'h1);
        chk_csr("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
        chk_csr("irq_mtval", 12'h343, 64'h0);
        chk_csr("irq_mstatus", 12'h300, 64'h1880);
        step();

        // Delegated illegal instruction from S-mode
        do_reset();
        wr(12'h302, 64'h4);
        wr(12'h105, 64'h300);
        wr(12'h300, 64'h800);
        wr(12'h341, 64'h500);
        do_mret();
        chk("mret_to_s_priv", 64'(privilege_mode), 64'h1);
        step();
        instr_valid = 1'b1;
        illegal_instruction = 1'b1;
        instruction = 32'hFFFF_FFFF;
        pc = 64'h600;
        step();
        idle_inputs();
        chk("deleg_redirect_pc", redirect_pc, 64'h300);
        chk("deleg_priv", 64'(privilege_mode), 64'h1);
        chk_csr("deleg_scause", 12'h142, 64'h2);
        chk_csr("deleg_stval", 12'h143, 64'hFFFF_FFFF);
        chk_csr("deleg_sepc", 12'h141, 64'h600);
        chk_csr("deleg_sstatus", 12'h100, 64'h100);
        chk_csr("deleg_mcause", 12'h342, 64'h0);
        step();

        // mret restoring U-mode with interrupts enabled
        do_reset();
        wr(12'h300, 64'h80);
        wr(12'h341, 64'h404);
        do_mret();
        chk("mret_priv", 64'(privilege_mode), 64'h0);
        chk("mret_redirect_pc", redirect_pc, 64'h404);
        chk_csr("mret_mstatus", 12'h300, 64'h88);
        step();

        // Reset during the redirect cycle cancels it
        instr_valid = 1'b1;
        ecall = 1'b1;
        step();
        idle_inputs();
        chk("pre_abort_redirect", 64'(redirect), 64'h1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_redirect", 64'(redirect), 64'h0);
        chk("abort_priv", 64'(privilege_mode), 64'h3);
        chk("abort_redirect_pc", redirect_pc, 64'h0);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) != 0);
            instr_valid = ($urandom_range(0, 9) < 7);
            illegal_instruction = ($urandom_range(0, 9) == 0);
            ecall = ($urandom_range(0, 9) == 0);
            mret = ($urandom_range(0, 9) == 0);
            sret = ($urandom_range(0, 9) == 0);
            ext_irq = ($urandom_range(0, 9) == 0);
            pc = {$urandom, $urandom};
            instruction = $urandom;
            csr_addr = addr_list[$urandom_range(0, 11)];
            csr_wr_en = ($urandom_range(0, 2) == 0);
            csr_wdata = {$urandom, $urandom};
            if (csr_addr == 12'h300 && csr_wdata[12:11] == 2'b10) csr_wdata[12:11] = 2'b11;
            #1;
            d = model_read(csr_addr, inv);
            chk("rand_rdata", csr_rdata, d);
            chk("rand_invalid", 64'(csr_addr_invalid), 64'(inv));
            step();
            chk("rand_redirect", 64'(redirect), 64'(m_redir));
            chk("rand_redirect_pc", redirect_pc, m_rpc);
            chk("rand_priv", 64'(privilege_mode), 64'(m_priv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
